pipe_stage_reg: RTL

Generic elastic pipeline register for the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field and a data field with a valid/ready handshake, synchronous flush that turns the slot into a bubble, a global enable (debug step), and an optional skid buffer. The skid buffer gives full throughput with a registered upstream ready.

---
 rtl/pipe_stage_reg.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register carrying a control and a data bundle across a MIPS stage boundary.
// Latency: an entry accepted in cycle N is presented in cycle N+1.
// Backpressure: SKID=1 uses a two-entry skid buffer with registered o_ready; SKID=0 uses one register with combinational o_ready.
module pipe_stage_reg #(
  parameter int                    CTRL_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    SKID        = 1,
  parameter logic [CTRL_WIDTH-1:0] BUBBLE_CTRL = '0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CTRL_WIDTH-1:0] o_ctrl,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_count
);

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FULL     = 2'd1,
    SKIDFULL = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  ready_q, ready_d;
  logic                  acc_in, acc_out;

  assign o_valid = (state_q != EMPTY);
  assign o_ctrl  = o_valid ? main_ctrl_q : BUBBLE_CTRL;
  assign o_data  = main_data_q;
  assign o_count = state_q;

  // With the skid buffer, ready comes straight from a flop so the upstream
  // timing path is cut; without it, ready looks through to i_ready.
  assign o_ready = (SKID != 0) ? (ready_q & i_enable)
                               : (i_enable & (~o_valid | i_ready));

  assign acc_in  = i_valid & o_ready & i_enable;
  assign acc_out = o_valid & i_ready & i_enable;

  // Next-state and datapath selection: flush beats handshake, enable low freezes all.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (i_enable) begin
      if (i_flush) begin
        // Held entries and any same-cycle input die; data regs keep stale values.
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (acc_in) begin
              state_d     = FULL;
              main_ctrl_d = i_ctrl;
              main_data_d = i_data;
            end
          end
          FULL: begin
            if (acc_in && acc_out) begin
              main_ctrl_d = i_ctrl;
              main_data_d = i_data;
            end else if (acc_out) begin
              state_d = EMPTY;
            end else if (acc_in) begin
              if (SKID != 0) begin
                // Downstream stalled in the same cycle we promised space: park in skid.
                state_d     = SKIDFULL;
                skid_ctrl_d = i_ctrl;
                skid_data_d = i_data;
              end else begin
                // Not reachable with combinational ready; kept for completeness.
                main_ctrl_d = i_ctrl;
                main_data_d = i_data;
              end
            end
          end
          SKIDFULL: begin
            // o_ready is low here, so only the drain can happen.
            if (acc_out) begin
              state_d     = FULL;
              main_ctrl_d = skid_ctrl_q;
              main_data_d = skid_data_q;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end
    ready_d = (state_d != SKIDFULL);
  end

  // State and bundle registers with asynchronous reset to an empty, ready stage.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      ready_q     <= ready_d;
    end
  end

endmodule
